// File: rtl/qspi_flash_ctrl.sv
// qspi_flash_ctrl -- quad-SPI flash read sequencer.
//
// Turns word read requests from the core memory bus into a complete
// quad-mode flash read: command byte, 24-bit address, dummy beats and
// 32 data bits. Each phase is one nibble per beat over a valid/ready
// interface to the downstream nibble shifter. The returned nibbles are
// assembled into a little-endian 32-bit word. The block also owns chip
// select framing, including the minimum deselect time between reads.
// Writes are not supported by the flash path: they are acknowledged and
// otherwise dropped.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   qspi_in    core request  (mem_valid, mem_addr, mem_wdata, mem_wstrb)
//   qspi_out   core response (mem_rdata, mem_ready)
//   phy_valid  nibble beat offered to the shifter
//   phy_ready  shifter accepts / completes the current beat
//   phy_oe     1 = drive phy_dout onto DQ, 0 = sample DQ into phy_din
//   phy_dout   nibble to drive
//   phy_din    nibble sampled from DQ (meaningful on beats with phy_oe = 0)
//   phy_cs     flash chip select, active-low

package qspi_flash_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

module qspi_flash_ctrl
    import qspi_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD = 8'hEB,
    parameter int         DUMMY    = 4,     // dummy beats, 0..15
    parameter int         CS_HIGH  = 2      // min deselect cycles, 1..255
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  qspi_in,
    output mem_out_type qspi_out,
    output logic        phy_valid,
    input  logic        phy_ready,
    output logic        phy_oe,
    output logic [3:0]  phy_dout,
    input  logic [3:0]  phy_din,
    output logic        phy_cs
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Last counter value of each phase before moving on.
    localparam logic [7:0] CMD_LAST   = 8'd1;
    localparam logic [7:0] ADDR_LAST  = 8'd5;
    localparam logic [7:0] DUMMY_LAST = 8'((DUMMY > 0) ? DUMMY - 1 : 0);
    localparam logic [7:0] DATA_LAST  = 8'd7;
    localparam logic [7:0] DONE_LAST  = 8'(CS_HIGH - 1);

    // After the address phase, skip the dummy phase entirely when it is empty.
    localparam logic [2:0] AFTER_ADDR = (DUMMY == 0) ? ST_DATA : ST_DUMMY;

    logic [2:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [23:0] addr_reg, addr_next;     // shifts left one nibble per address beat
    logic [31:0] data_reg, data_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        ready_reg, ready_next;

    logic        beat;
    logic [31:0] capture_word;

    // Only a 24-bit word-aligned address reaches the flash, and write data is
    // never used because writes are dropped.
    logic unused_in;
    assign unused_in = ^{qspi_in.mem_wdata, qspi_in.mem_addr[31:24], qspi_in.mem_addr[1:0]};

    assign beat = phy_valid & phy_ready;

    // Data beat k lands in nibble slot k^1. Even beats are the high nibble of
    // byte k/2 and odd beats the low nibble, so bytes assemble little-endian.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            localparam logic [2:0] BEAT_IDX = 3'(gi ^ 1);
            assign capture_word[4*gi +: 4] = (cnt_reg[2:0] == BEAT_IDX) ? phy_din
                                                                         : data_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        rdata_next = rdata_reg;
        ready_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // ready_reg still high means the write acknowledged last
                // cycle is still being presented; do not take it twice.
                if (qspi_in.mem_valid && !ready_reg) begin
                    if (qspi_in.mem_wstrb == 4'h0) begin
                        addr_next  = {qspi_in.mem_addr[23:2], 2'b00};
                        state_next = ST_CMD;
                        cnt_next   = 8'd0;
                    end else begin
                        ready_next = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (beat) begin
                    if (cnt_reg == CMD_LAST) begin
                        state_next = ST_ADDR;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (beat) begin
                    addr_next = {addr_reg[19:0], 4'h0};
                    if (cnt_reg == ADDR_LAST) begin
                        state_next = AFTER_ADDR;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            ST_DUMMY: begin
                if (beat) begin
                    if (cnt_reg == DUMMY_LAST) begin
                        state_next = ST_DATA;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (beat) begin
                    data_next = capture_word;
                    if (cnt_reg == DATA_LAST) begin
                        // Publish the word including the final nibble so the
                        // response is valid in the first DONE cycle.
                        rdata_next = capture_word;
                        ready_next = 1'b1;
                        state_next = ST_DONE;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (cnt_reg == DONE_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            addr_reg  <= 24'd0;
            data_reg  <= 32'd0;
            rdata_reg <= 32'd0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            rdata_reg <= rdata_next;
            ready_reg <= ready_next;
        end
    end

    // PHY controls decode straight from registered state. They only change
    // on a beat edge, so they hold steady through phy_ready stalls.
    always_comb begin
        phy_valid = 1'b0;
        phy_oe    = 1'b1;
        phy_dout  = 4'h0;
        case (state_reg)
            ST_CMD: begin
                phy_valid = 1'b1;
                phy_dout  = cnt_reg[0] ? READ_CMD[3:0] : READ_CMD[7:4];
            end
            ST_ADDR: begin
                phy_valid = 1'b1;
                phy_dout  = addr_reg[23:20];
            end
            ST_DUMMY, ST_DATA: begin
                phy_valid = 1'b1;
                phy_oe    = 1'b0;
            end
            default: begin
                phy_valid = 1'b0;
            end
        endcase
    end

    // Chip select is low exactly while beats are on offer, which keeps it
    // continuously low from the first command beat to the last data beat.
    assign phy_cs = ~phy_valid;

    assign qspi_out.mem_ready = ready_reg;
    assign qspi_out.mem_rdata = rdata_reg;

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Testbench for qspi_flash_ctrl: table of read/write transactions with
// hand-computed expectations, plus sequences for back-to-back reads and
// a reset abort. A second instance is built with DUMMY = 0.
module tb_qspi_flash_ctrl;
    import qspi_flash_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_in_type  req_a, req_b;
    mem_out_type rsp_a, rsp_b;
    logic        pv_a, pr_a, oe_a, cs_a;
    logic [3:0]  do_a, di_a;
    logic        pv_b, pr_b, oe_b, cs_b;
    logic [3:0]  do_b, di_b;

    qspi_flash_ctrl #(.READ_CMD(8'hEB), .DUMMY(4), .CS_HIGH(2)) u_dut (
        .clock(clock), .reset(reset), .qspi_in(req_a), .qspi_out(rsp_a),
        .phy_valid(pv_a), .phy_ready(pr_a), .phy_oe(oe_a), .phy_dout(do_a),
        .phy_din(di_a), .phy_cs(cs_a)
    );

    qspi_flash_ctrl #(.READ_CMD(8'hEB), .DUMMY(0), .CS_HIGH(2)) u_dut_nodummy (
        .clock(clock), .reset(reset), .qspi_in(req_b), .qspi_out(rsp_b),
        .phy_valid(pv_b), .phy_ready(pr_b), .phy_oe(oe_b), .phy_dout(do_b),
        .phy_din(di_b), .phy_cs(cs_b)
    );

    typedef struct {
        int          sel;        // 0 = DUMMY 4 instance, 1 = DUMMY 0 instance
        logic [31:0] addr;
        logic [3:0]  wstrb;
        int          mode;       // 0: ready=1, 1: ready on odd cycles, 2: on even cycles
        logic [31:0] din;        // data nibbles, first beat in bits 31:28
        logic [31:0] exp_out;    // first 8 driven nibbles, first in bits 31:28
        logic [31:0] exp_rdata;
        int          exp_lat;    // cycle of mem_ready, acceptance cycle = 1
        int          exp_beats;
        int          exp_oe1;
        int          dummy;
    } vec_t;

    vec_t tbl[7];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int sel, input logic valid, input logic [31:0] addr,
                             input logic [3:0] wstrb);
        if (sel == 0) begin
            req_a.mem_valid = valid; req_a.mem_addr = addr;
            req_a.mem_wdata = 32'hDEADBEEF; req_a.mem_wstrb = wstrb;
        end else begin
            req_b.mem_valid = valid; req_b.mem_addr = addr;
            req_b.mem_wdata = 32'hDEADBEEF; req_b.mem_wstrb = wstrb;
        end
    endtask

    task automatic drive_phy(input int sel, input logic rdy, input logic [3:0] din);
        if (sel == 0) begin pr_a = rdy; di_a = din; end
        else          begin pr_b = rdy; di_b = din; end
    endtask

    task automatic sample(input int sel, output logic pv, output logic oe, output logic cs,
                          output logic mr, output logic [3:0] dout, output logic [31:0] rd);
        if (sel == 0) begin
            pv = pv_a; oe = oe_a; cs = cs_a; mr = rsp_a.mem_ready; dout = do_a; rd = rsp_a.mem_rdata;
        end else begin
            pv = pv_b; oe = oe_b; cs = cs_b; mr = rsp_b.mem_ready; dout = do_b; rd = rsp_b.mem_rdata;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int pulses = 0, nbeats = 0, oe1 = 0, oe0 = 0, stall_bad = 0, cs_bad = 0, lat = 0, k;
        logic [31:0] outw = 32'h0, rd = 32'h0, rdat;
        logic pv, oe, cs, mr, rdy, pend = 1'b0, pend_oe = 1'b0;
        logic [3:0] dout, din_n, pend_dout = 4'h0;
        @(negedge clock); #1;
        drive_req(v.sel, 1'b1, v.addr, v.wstrb);
        for (int c = 1; c <= 80; c++) begin
            if (pulses > 0) drive_req(v.sel, 1'b0, 32'h0, 4'h0);
            rdy = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'(c % 2) : 1'(1 - c % 2);
            sample(v.sel, pv, oe, cs, mr, dout, rdat);
            din_n = 4'hA;
            if (pv && !oe) begin
                k = oe0 - v.dummy;
                if (k >= 0 && k < 8) din_n = 4'(v.din >> (28 - 4 * k));
            end
            drive_phy(v.sel, rdy, din_n);
            if (pv === cs) cs_bad++;
            if (pend && (!pv || dout !== pend_dout || oe !== pend_oe)) stall_bad++;
            if (pv && rdy) begin
                if (nbeats < 8) outw = {outw[27:0], dout};
                if (oe) oe1++; else oe0++;
                nbeats++;
                pend = 1'b0;
            end else begin
                pend = pv; pend_dout = dout; pend_oe = oe;
            end
            if (mr) begin
                pulses++;
                if (pulses == 1) begin lat = c; rd = rdat; end
            end
            if (pulses > 0 && c >= lat + 4) break;
            @(negedge clock); #1;
        end
        drive_req(v.sel, 1'b0, 32'h0, 4'h0);
        drive_phy(v.sel, 1'b0, 4'h0);
        $display("vec %0d: sel=%0d addr=%h wstrb=%h mode=%0d lat=%0d rdata=%h beats=%0d",
                 idx, v.sel, v.addr, v.wstrb, v.mode, lat, rd, nbeats);
        chk($sformatf("vec%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("vec%0d rdata", idx), rd, v.exp_rdata);
        chk($sformatf("vec%0d ready_pulses", idx), pulses, 1);
        chk($sformatf("vec%0d beats", idx), nbeats, v.exp_beats);
        chk($sformatf("vec%0d out_nibbles", idx), outw, v.exp_out);
        chk($sformatf("vec%0d oe_beats", idx), oe1, v.exp_oe1);
        chk($sformatf("vec%0d stall_stable", idx), stall_bad, 0);
        chk($sformatf("vec%0d cs_framing", idx), cs_bad, 0);
    endtask

    initial begin
        logic pv, oe, cs, mr;
        logic [3:0] dout;
        logic [31:0] rd, rdat;
        int pulses, c1, c2, run, nb;
        logic second, reached;

        tbl[0] = '{0, 32'h00123454, 4'h0, 0, 32'h12345678, 32'hEB123454, 32'h78563412, 22, 20, 8, 4};
        tbl[1] = '{0, 32'h00123454, 4'h0, 1, 32'h12345678, 32'hEB123454, 32'h78563412, 42, 20, 8, 4};
        tbl[2] = '{0, 32'h00000100, 4'hF, 0, 32'h00000000, 32'h00000000, 32'h78563412,  2,  0, 0, 4};
        tbl[3] = '{0, 32'hFFABCDEF, 4'h0, 0, 32'hA5C30F96, 32'hEBABCDEC, 32'h960FC3A5, 22, 20, 8, 4};
        tbl[4] = '{0, 32'h00000004, 4'h1, 0, 32'h00000000, 32'h00000000, 32'h960FC3A5,  2,  0, 0, 4};
        tbl[5] = '{0, 32'h00FFFFFC, 4'h0, 2, 32'hFFFFFFFF, 32'hEBFFFFFC, 32'hFFFFFFFF, 41, 20, 8, 4};
        tbl[6] = '{1, 32'h00123454, 4'h0, 0, 32'h12345678, 32'hEB123454, 32'h78563412, 18, 16, 8, 0};

        req_a = '0; req_b = '0;
        pr_a = 1'b0; di_a = 4'h0; pr_b = 1'b0; di_b = 4'h0;

        // Reset state.
        #2;
        chk("rst phy_valid", pv_a, 0);
        chk("rst phy_oe", oe_a, 1);
        chk("rst phy_dout", do_a, 0);
        chk("rst phy_cs", cs_a, 1);
        chk("rst mem_ready", rsp_a.mem_ready, 0);
        chk("rst mem_rdata", rsp_a.mem_rdata, 0);
        @(negedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // Back-to-back reads with mem_valid held across both.
        @(negedge clock); #1;
        drive_req(0, 1'b1, 32'h00000010, 4'h0);
        pulses = 0; c1 = 0; c2 = 0; run = 0; second = 1'b0; rd = 32'h0;
        for (int c = 1; c <= 100; c++) begin
            if (pulses >= 2) drive_req(0, 1'b0, 32'h0, 4'h0);
            drive_phy(0, 1'b1, 4'h5);
            sample(0, pv, oe, cs, mr, dout, rdat);
            if (mr) begin
                pulses++;
                if (pulses == 1) c1 = c;
                else if (pulses == 2) begin c2 = c; rd = rdat; end
            end
            if (pulses == 1 && !second) begin
                if (cs) run++; else second = 1'b1;
            end
            if (c2 > 0 && c >= c2 + 4) break;
            @(negedge clock); #1;
        end
        drive_req(0, 1'b0, 32'h0, 4'h0);
        drive_phy(0, 1'b0, 4'h0);
        $display("b2b: first ready cycle %0d, second %0d, cs high run %0d, rdata=%h", c1, c2, run, rd);
        chk("b2b pulses", pulses, 2);
        chk("b2b first latency", c1, 22);
        chk("b2b spacing", c2 - c1, 23);
        chk("b2b cs_high_run", run, 3);
        chk("b2b rdata", rd, 32'h55555555);

        // Reset pulsed during ADDR beat 3 (sixth overall beat).
        @(negedge clock); #1;
        drive_req(0, 1'b1, 32'h00123454, 4'h0);
        nb = 0; reached = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            drive_phy(0, 1'b1, 4'h3);
            sample(0, pv, oe, cs, mr, dout, rdat);
            if (nb == 5 && pv) begin reached = 1'b1; break; end
            if (pv) nb++;
            @(negedge clock); #1;
        end
        chk("abort reached ADDR beat 3", reached, 1);
        reset = 1'b0;
        drive_req(0, 1'b0, 32'h0, 4'h0);
        #1;
        $display("abort: reset asserted mid-ADDR, cs=%b valid=%b ready=%b", cs_a, pv_a, rsp_a.mem_ready);
        chk("abort phy_cs", cs_a, 1);
        chk("abort phy_valid", pv_a, 0);
        chk("abort mem_ready", rsp_a.mem_ready, 0);
        chk("abort phy_oe", oe_a, 1);
        chk("abort phy_dout", do_a, 0);
        chk("abort mem_rdata", rsp_a.mem_rdata, 0);
        @(negedge clock); #1;
        reset = 1'b1;
        pulses = 0; nb = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_a.mem_ready) pulses++;
            if (pv_a) nb++;
            @(negedge clock); #1;
        end
        chk("abort no ready", pulses, 0);
        chk("abort no beats", nb, 0);
        run_vec(7, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
